// File: rtl/rv32v_fetch2_stage.sv
// Second fetch stage: in-order slot buffer between imem responses and decode.
// Fetch1 allocates a slot per imem request; responses fill slots in order;
// the head slot is presented to decode. Flush converts every outstanding
// request into a pending drop so its late response is discarded.
module rv32v_fetch2_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        flush,
  input  logic        decode_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] instr,
  output logic        mal_insn,
  output logic        fault_insn
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // used + drop_cnt never exceeds 2*DEPTH, so size both counters for that
  localparam int CW = $clog2(2*DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        mal;
    logic        fault;
    logic        filled;
  } slot_t;

  slot_t          slots [DEPTH];
  slot_t          head;
  logic [PW-1:0]  alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]  used;      // allocated, not yet popped
  logic [CW-1:0]  pend;      // allocated, not yet filled
  logic [CW-1:0]  drop_cnt;  // responses still owed to flushed requests
  logic           do_alloc, do_fill, do_drop, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes and head presentation; the full test uses the pre-pop count
  always_comb begin
    head       = slots[head_ptr];
    req_ready  = (used < CW'(DEPTH)) && !flush;
    out_valid  = head.filled && !flush;
    out_pc     = head.pc;
    mal_insn   = out_valid && head.mal;
    fault_insn = out_valid && head.fault;
    instr      = (out_valid && !head.mal && !head.fault) ? head.word : NOP_INSTR;
    do_alloc   = req_valid && req_ready;
    do_drop    = imem_rvalid && (drop_cnt != '0);
    // a stray response (nothing owed, nothing unfilled) matches neither case
    do_fill    = imem_rvalid && (drop_cnt == '0) && (pend != '0);
    do_pop     = out_valid && decode_ready;
  end

  // Pointers and counters; flush collapses the buffer and owes its unfilled slots as drops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      fill_ptr  <= alloc_ptr;
      head_ptr  <= alloc_ptr;
      used      <= '0;
      pend      <= '0;
      // the arriving response settles against the old drop count first
      drop_cnt  <= drop_cnt - CW'(do_drop) + pend - CW'(do_fill);
    end else begin
      if (do_alloc) alloc_ptr <= inc(alloc_ptr);
      if (do_fill)  fill_ptr  <= inc(fill_ptr);
      if (do_pop)   head_ptr  <= inc(head_ptr);
      used     <= used + CW'(do_alloc) - CW'(do_pop);
      pend     <= pend + CW'(do_alloc) - CW'(do_fill);
      drop_cnt <= drop_cnt - CW'(do_drop);
    end
  end

  // Slot contents; popped slots lose their filled bit so a stale entry never re-presents
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      if (do_alloc) begin
        slots[alloc_ptr].pc     <= req_pc;
        slots[alloc_ptr].mal    <= (req_pc[1:0] != 2'b00);
        slots[alloc_ptr].filled <= 1'b0;
      end
      if (do_fill) begin
        slots[fill_ptr].word   <= imem_rdata;
        slots[fill_ptr].fault  <= imem_err;
        slots[fill_ptr].filled <= 1'b1;
      end
      if (do_pop) slots[head_ptr].filled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32v_fetch2_stage.sv
// Directed bench for rv32v_fetch2_stage: streaming, stall, fault/misalign,
// flush with in-flight responses, flush collisions and async reset.
module tb_rv32v_fetch2_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, imem_rvalid, imem_err, flush, decode_ready;
  logic [31:0] req_pc, imem_rdata;
  logic        req_ready, out_valid, mal_insn, fault_insn;
  logic [31:0] out_pc, instr;

  int checks = 0;
  int errors = 0;

  rv32v_fetch2_stage #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .flush(flush), .decode_ready(decode_ready),
    .out_valid(out_valid), .out_pc(out_pc), .instr(instr),
    .mal_insn(mal_insn), .fault_insn(fault_insn)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req_valid   = 1'b0;
    req_pc      = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_err    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic req(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
  endtask

  task automatic rsp(input logic [31:0] w, input logic e);
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    imem_err    = e;
  endtask

  task automatic head_is(input string tag, input logic [31:0] pc, input logic [31:0] w);
    chk({tag, "_vld"},   32'(out_valid), 1);
    chk({tag, "_pc"},    out_pc, pc);
    chk({tag, "_instr"}, instr, w);
  endtask

  initial begin
    idle();
    decode_ready = 1'b0;
    RST = 1'b1;
    #12;
    // reset state
    chk("rst_vld",   32'(out_valid), 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_mal",   32'(mal_insn), 0);
    chk("rst_fault", 32'(fault_insn), 0);
    RST = 1'b0;
    #1;
    chk("rst_rdy", 32'(req_ready), 1);
    tick();

    // streaming with one-cycle response latency
    decode_ready = 1'b1;
    req(32'h100); #1; chk("st0_rdy", 32'(req_ready), 1); tick();
    req(32'h104); rsp(32'hA, 0); #1; chk("st1_vld", 32'(out_valid), 0); chk("st1_rdy", 32'(req_ready), 1); tick();
    // two slots held before the pop: no same-cycle reuse
    req(32'h108); rsp(32'hB, 0); #1; head_is("st2", 32'h100, 32'hA); chk("st2_rdy", 32'(req_ready), 0); tick();
    idle(); req(32'h108); #1; head_is("st3", 32'h104, 32'hB); chk("st3_rdy", 32'(req_ready), 1); tick();
    idle(); rsp(32'hC, 0); #1; chk("st4_vld", 32'(out_valid), 0); tick();
    idle(); #1; head_is("st5", 32'h108, 32'hC); tick();
    #1; chk("st6_vld", 32'(out_valid), 0);

    // stall and full
    decode_ready = 1'b0;
    req(32'h400); tick();
    req(32'h404); rsp(32'h11, 0); tick();
    idle(); rsp(32'h22, 0); #1; head_is("sf2", 32'h400, 32'h11); chk("sf2_rdy", 32'(req_ready), 0); tick();
    idle(); #1; head_is("sf3", 32'h400, 32'h11); chk("sf3_rdy", 32'(req_ready), 0); tick();
    decode_ready = 1'b1; req(32'h408); #1; chk("sf4_rdy", 32'(req_ready), 0); head_is("sf4", 32'h400, 32'h11); tick();
    #1; chk("sf5_rdy", 32'(req_ready), 1); head_is("sf5", 32'h404, 32'h22); tick();
    idle(); rsp(32'h33, 0); #1; chk("sf6_vld", 32'(out_valid), 0); tick();
    idle(); #1; head_is("sf7", 32'h408, 32'h33); tick();

    // misaligned PC
    req(32'h102); tick();
    idle(); rsp(32'h12345678, 0); tick();
    idle(); #1;
    head_is("mal", 32'h102, NOP);
    chk("mal_flag", 32'(mal_insn), 1);
    chk("mal_flt",  32'(fault_insn), 0);
    tick();

    // bus fault
    req(32'h200); tick();
    idle(); rsp(32'hDEAD, 1); tick();
    idle(); #1;
    head_is("flt", 32'h200, NOP);
    chk("flt_flag", 32'(fault_insn), 1);
    chk("flt_mal",  32'(mal_insn), 0);
    tick();

    // flush with two requests in flight: their responses must be dropped
    req(32'h500); tick();
    req(32'h504); tick();
    idle(); flush = 1'b1; #1; chk("fl_vld", 32'(out_valid), 0); chk("fl_rdy", 32'(req_ready), 0); tick();
    idle(); req(32'h300); rsp(32'hD1, 0); #1; chk("fl1_rdy", 32'(req_ready), 1); tick();
    idle(); rsp(32'hD2, 0); #1; chk("fl2_vld", 32'(out_valid), 0); tick();
    idle(); rsp(32'hE0, 0); #1; chk("fl3_vld", 32'(out_valid), 0); tick();
    idle(); #1; head_is("fl4", 32'h300, 32'hE0); tick();
    #1; chk("fl5_vld", 32'(out_valid), 0);

    // flush colliding with alloc, fill and pop: outstanding slot is filled, nothing owed
    decode_ready = 1'b0;
    req(32'h600); tick();
    req(32'h604); rsp(32'h61, 0); tick();
    idle(); #1; head_is("ca0", 32'h600, 32'h61);
    decode_ready = 1'b1; flush = 1'b1; req(32'h6F0); rsp(32'h62, 0); #1;
    chk("ca1_vld", 32'(out_valid), 0); chk("ca1_rdy", 32'(req_ready), 0); tick();
    idle(); req(32'h700); #1; chk("ca2_vld", 32'(out_valid), 0); chk("ca2_rdy", 32'(req_ready), 1); tick();
    idle(); rsp(32'h70, 0); tick();
    idle(); #1; head_is("ca4", 32'h700, 32'h70); tick();

    // flush colliding with a response owed to an earlier flush, one other outstanding
    req(32'h800); tick();
    req(32'h804); tick();
    idle(); flush = 1'b1; tick();
    idle(); req(32'h808); tick();
    idle(); flush = 1'b1; req(32'h80C); rsp(32'hB1, 0); #1;
    chk("cb4_rdy", 32'(req_ready), 0); chk("cb4_vld", 32'(out_valid), 0); tick();
    idle(); req(32'h900); rsp(32'hB2, 0); #1; chk("cb5_rdy", 32'(req_ready), 1); tick();
    idle(); rsp(32'hB3, 0); #1; chk("cb6_vld", 32'(out_valid), 0); tick();
    idle(); rsp(32'h90, 0); #1; chk("cb7_vld", 32'(out_valid), 0); tick();
    idle(); #1; head_is("cb8", 32'h900, 32'h90); tick();

    // async reset between edges with two slots in use
    decode_ready = 1'b0;
    req(32'hA00); tick();
    req(32'hA04); rsp(32'hAA, 0); tick();
    idle(); rsp(32'hAB, 0); tick();
    idle(); #1; head_is("ar0", 32'hA00, 32'hAA); chk("ar0_rdy", 32'(req_ready), 0);
    #1; RST = 1'b1; #1;
    chk("ar_vld",   32'(out_valid), 0);
    chk("ar_instr", instr, NOP);
    chk("ar_pc",    out_pc, 0);
    chk("ar_mal",   32'(mal_insn), 0);
    chk("ar_fault", 32'(fault_insn), 0);
    RST = 1'b0; #1;
    chk("ar_rdy", 32'(req_ready), 1);
    tick();
    decode_ready = 1'b1;
    req(32'hB00); tick();
    idle(); rsp(32'hBB, 0); tick();
    idle(); #1; head_is("ar3", 32'hB00, 32'hBB); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
